// File: rtl/spi_tx_queue.sv
// Byte FIFO plus launch sequencer in front of spi_master_tx: pops one byte per
// frame, holds send until the master goes busy, and enforces an idle gap between frames.
module spi_tx_queue #(
    parameter int DEPTH       = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int ARM_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               wr_data,
    input  logic                     wr_en,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     timeout_err,
    output logic [7:0]               data_out,
    output logic                     send,
    input  logic                     m_busy,
    output logic                     tx_active
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = $clog2(ARM_TIMEOUT + 2);
    localparam int GW = $clog2(GAP_CYCLES + 2);

    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [AW-1:0] ARM_ONE    = AW'(1);
    localparam logic [AW-1:0] ARM_LIMIT  = AW'(ARM_TIMEOUT);
    localparam logic [GW-1:0] GAP_ONE    = GW'(1);
    localparam logic [GW-1:0] GAP_LIMIT  = GW'(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        XFER = 2'd2,
        GAP  = 2'd3
    } state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q;
    logic          overflow_q, overflow_d;
    logic          wr_accept;
    logic          pop;

    state_t        state_q;
    logic          send_q;
    logic [7:0]    data_out_q;
    logic          timeout_q;
    logic          tx_active_q;
    logic [AW-1:0] arm_cnt_q;
    logic [GW-1:0] gap_cnt_q;

    // Fullness comes from registered state, so a same-cycle pop never frees room for a write.
    always_comb begin
        wr_accept  = wr_en && !full_q;
        pop        = (state_q == IDLE) && !empty_q && !m_busy;
        wr_ptr_d   = wr_accept ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d    = count_q;
        if (wr_accept && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!wr_accept && pop) begin
            count_d = count_q - CNT_ONE;
        end
        overflow_d = overflow_q || (wr_en && full_q);
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == FULL_COUNT);
            empty_q    <= (count_d == '0);
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            send_q      <= 1'b0;
            data_out_q  <= 8'h00;
            timeout_q   <= 1'b0;
            tx_active_q <= 1'b0;
            arm_cnt_q   <= '0;
            gap_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        data_out_q  <= mem_q[rd_ptr_q];
                        send_q      <= 1'b1;
                        arm_cnt_q   <= '0;
                        tx_active_q <= 1'b1;
                        state_q     <= ARM;
                    end
                end
                ARM: begin
                    // Drop send on the first busy cycle so the master cannot relaunch the byte.
                    if (m_busy) begin
                        send_q  <= 1'b0;
                        state_q <= XFER;
                    end else if (arm_cnt_q == ARM_LIMIT) begin
                        send_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        gap_cnt_q <= '0;
                        state_q   <= GAP;
                    end else begin
                        arm_cnt_q <= arm_cnt_q + ARM_ONE;
                    end
                end
                XFER: begin
                    if (!m_busy) begin
                        gap_cnt_q <= '0;
                        state_q   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GAP_LIMIT) begin
                        tx_active_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign full        = full_q;
    assign empty       = empty_q;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_q;
    assign data_out    = data_out_q;
    assign send        = send_q;
    assign tx_active   = tx_active_q;

endmodule

// File: tb/tb_spi_tx_queue.sv
// Random writes and a randomly responding master model, with every cycle's outputs
// checked against a queue-and-timestamp reference of the queue/launch rules.
module tb_spi_tx_queue;

    localparam int DEPTH = 8;
    localparam int GAP   = 4;
    localparam int ATO   = 20;
    localparam int CYC_PER_PHASE = 1500;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full, empty, overflow, timeout_err, send, tx_active;
    logic [$clog2(DEPTH):0] count;
    logic [7:0] data_out;
    logic       m_busy;

    always #5 clk = ~clk;

    spi_tx_queue #(
        .DEPTH       (DEPTH),
        .GAP_CYCLES  (GAP),
        .ARM_TIMEOUT (ATO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .data_out    (data_out),
        .send        (send),
        .m_busy      (m_busy),
        .tx_active   (tx_active)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: the queue is an SV queue; sequencing is tracked by edge timestamps.
    logic [7:0] ref_q[$];
    int   t = 0;
    bit   r_active, r_armed, r_wait_fall;
    int   arm_start, idle_at;
    logic [7:0] e_data;
    bit   e_send, e_ovf, e_to;
    int   n_launch = 0;

    task automatic model_reset();
        ref_q.delete();
        r_active = 0; r_armed = 0; r_wait_fall = 0;
        e_data = 8'h00; e_send = 0; e_ovf = 0; e_to = 0;
        idle_at = -1; arm_start = 0;
    endtask

    task automatic model_step();
        bit was_full;
        t++;
        if (rst) begin
            model_reset();
            return;
        end
        was_full = (ref_q.size() == DEPTH);
        if (!r_active) begin
            if (ref_q.size() > 0 && !m_busy) begin
                e_data    = ref_q.pop_front();
                e_send    = 1;
                r_active  = 1;
                r_armed   = 1;
                arm_start = t;
                n_launch++;
                $display("launch %0d: byte 0x%02h at edge %0d", n_launch, e_data, t);
            end
        end else if (r_armed) begin
            if (m_busy) begin
                e_send = 0; r_armed = 0; r_wait_fall = 1;
            end else if (t - arm_start == ATO + 1) begin
                e_send = 0; r_armed = 0; e_to = 1;
                idle_at = t + GAP + 1;
            end
        end else if (r_wait_fall) begin
            if (!m_busy) begin
                r_wait_fall = 0;
                idle_at = t + GAP + 1;
            end
        end else if (t == idle_at) begin
            r_active = 0;
        end
        if (wr_en) begin
            if (was_full) e_ovf = 1;
            else ref_q.push_back(wr_data);
        end
    endtask

    // Master model state
    int  busy_left = 0;
    int  delay = 0;
    bit  responding = 0;

    task automatic drive_master();
        if (busy_left > 0) begin
            m_busy = 1'b1;
            busy_left--;
        end else begin
            m_busy = 1'b0;
            if (send) begin
                if (!responding) begin
                    responding = 1;
                    delay = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 3));
                end
                if (delay == 0) begin
                    m_busy = 1'b1;
                    busy_left = $urandom_range(1, 8);
                    responding = 0;
                end else begin
                    delay--;
                end
            end else begin
                responding = 0;
                if ($urandom_range(0, 39) == 0) begin
                    m_busy = 1'b1;
                    busy_left = $urandom_range(0, 2);
                end
            end
        end
    endtask

    task automatic compare_outputs();
        check("count", 32'(count), 32'(ref_q.size()));
        check("flags", {26'd0, full, empty, overflow, timeout_err, send, tx_active},
              {26'd0, ref_q.size() == DEPTH, ref_q.size() == 0, e_ovf, e_to, e_send, r_active});
        check("data_out", 32'(data_out), 32'(e_data));
    endtask

    initial begin
        int wr_pct;
        bit rst_pending;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; m_busy = 1'b0;
        model_reset();
        repeat (2) begin
            @(posedge clk); model_step();
        end
        #1 compare_outputs();

        for (int p = 0; p < 4; p++) begin
            wr_pct = (p == 0) ? 10 : (p == 1) ? 40 : (p == 2) ? 80 : 100;
            rst_pending = (p != 0);
            for (int c = 0; c < CYC_PER_PHASE; c++) begin
                @(negedge clk);
                rst = 1'b0;
                if (rst_pending && r_wait_fall && ref_q.size() > 0) begin
                    rst = 1'b1;
                    rst_pending = 0;
                    $display("reset mid-transfer with %0d bytes queued", ref_q.size());
                end
                wr_en   = ($urandom_range(1, 100) <= wr_pct);
                wr_data = 8'($urandom_range(0, 255));
                if (p == 3 && c >= CYC_PER_PHASE / 2) wr_en = 1'b0;
                drive_master();
                @(posedge clk);
                model_step();
                #1 compare_outputs();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
